mem_access_master: RTL and testbench
====================================

// Module: mem_access_master
// PURPOSE
//  Initiator side of the memory port: drives memWrite/memRead/addr/dataIn of the memory and captures its dataOut.
//  Accepts single or burst requests (1..8 beats) from the datapath through a valid/ready handshake.
//  Sequences them onto the memory port one beat per cycle and returns read data with a per-beat valid.
//  Sits between the datapath/load-store logic and the memory block.
// PARAMETERS
//  ADDR_W    8  address width; addresses wrap modulo 2**ADDR_W
//  DATA_W    8  data width
//  LEN_W     3  burst length field; beats = req_len + 1 (1..2**LEN_W)
//  READ_LAT  1  cycles from memRead/addr presented to dataOut valid (legal 1..4)
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst_n      in   1       synchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       master idle, can accept a request
//  req_write  in   1       1 = write burst, 0 = read burst
//  req_addr   in   ADDR_W  start address
//  req_wdata  in   DATA_W  write seed; beat i writes req_wdata + i (mod 2**DATA_W)
//  req_len    in   LEN_W   beats minus one
//  memWrite   out  1       memory write strobe
//  memRead    out  1       memory read strobe
//  addr       out  ADDR_W  memory address
//  dataIn     out  DATA_W  memory write data
//  dataOut    in   DATA_W  memory read data
//  resp_valid out  1       one-cycle pulse per returned read beat
//  resp_data  out  DATA_W  read data, valid with resp_valid
//  done       out  1       one-cycle pulse when a request fully completes
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; req_ready=1.
//   memWrite, memRead, addr, dataIn, resp_valid, resp_data and done all 0; latency pipe cleared.
//  All outputs are registered.
//  Handshake: accept on posedge with req_valid & req_ready; request fields are latched then.
//   req_ready=1 only in IDLE; requests offered while busy are ignored and not queued.
//  FSM states IDLE, WRITE, READ, DRAIN, DONE.
//  IDLE  -> WRITE if the accepted req_write=1, else READ.
//  WRITE: one beat per cycle.
//   memWrite=1, addr=start+i, dataIn=seed+i, for i=0..len.
//   After the last beat -> DONE.
//  READ: one beat per cycle, memRead=1, addr=start+i.
//   Each issued beat enters a READ_LAT-deep valid pipe.
//   When the pipe exits: resp_valid=1 and resp_data=dataOut sampled that cycle.
//   After the last issue -> DRAIN.
//  DRAIN: memRead=0; wait until the pipe is empty and the last resp_valid has been emitted -> DONE.
//  DONE: done=1 for exactly one cycle, strobes 0 -> IDLE (req_ready=1 the next cycle).
//  Latency: the first strobe is asserted 1 cycle after accept.
//   Read beat i: resp_valid asserts 1+i+READ_LAT cycles after accept.
//   done asserts the cycle after the last write beat / last resp_valid.
//  Invariants: memWrite and memRead are never both 1.
//   When a strobe is 0, addr/dataIn hold their last value; dataIn is held during reads.
//  Address wrap: 0xFF+1 -> 0x00 within a burst. Write-data increment also wraps.
//  Single beat (req_len=0): exactly one strobe cycle.
//  Reset mid-burst: the burst is aborted next edge; all outputs return to reset values.
//   No further resp_valid or done for the aborted request.
//  X on dataOut while no beat is exiting the pipe has no effect on outputs.
// STRUCTURE
//  Package mem_pkg holds:
//   - typedef enum logic [2:0] state_t {IDLE, WRITE, READ, DRAIN, DONE};
//   - default ADDR_W/DATA_W/LEN_W localparams;
//   - typedef addr_t / data_t.
//  Sub-module rd_valid_pipe (#(DEPTH=READ_LAT)):
//   - shift register of valid bits, sync active-low clear;
//   - outputs exit_valid and busy (any bit set).
//  The top holds the FSM plus the beat counter, address counter and data counter.
// TESTING (bench instantiates the memory block as the responder)
//  1. Write burst: addr=0x00, seed=0x00, len=7 -> memWrite high 8 consecutive cycles.
//     addr/dataIn 0..7 in order; done 1 cycle after the last beat; never memRead.
//  2. Read burst: addr=0x00, len=7 after test 1 -> 8 resp_valid pulses, resp_data 0x00..0x07.
//     First pulse 1+READ_LAT cycles after accept; done once.
//  3. Wrap: write addr=0xFE, seed=0xFF, len=3 -> addr FE,FF,00,01; dataIn FF,00,01,02.
//     A read-back returns the same values.
//  4. Busy: offer a second req_valid during a burst -> req_ready=0 and the request is ignored.
//     The same request is accepted the cycle after done.
//  5. Reset mid-read: rst_n=0 on the 3rd beat of an 8-beat read.
//     Next cycle all outputs 0; no later resp_valid/done; req_ready=1.
//  6. Single beat: len=0 read at 0x05 -> exactly one memRead cycle.
//     One resp_valid with the data written there; repeat with READ_LAT=3.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory access master.
package mem_pkg;
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_LEN_W  = 3;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [MEM_DATA_W-1:0] data_t;
endpackage

// File: rtl/rd_valid_pipe.sv
// Read-latency tracker: one valid bit per issued read beat, shifted DEPTH times.
// Ports: clk, clr_n (sync active-low clear), issue (beat issued this edge),
//        exit_valid (beat's data is on dataOut this cycle), busy (any beat in flight).
module rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic issue,
  output logic exit_valid,
  output logic busy
);
  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!clr_n) vld_pipe <= '0;
    else        vld_pipe <= DEPTH'({vld_pipe, issue});
  end

  assign exit_valid = vld_pipe[DEPTH-1];
  assign busy       = |vld_pipe;
endmodule

// File: rtl/mem_access_master.sv
// Memory port initiator: accepts single/burst requests over valid/ready and
// sequences them one beat per cycle onto memWrite/memRead/addr/dataIn,
// returning read data with a per-beat resp_valid and a done pulse.
// Ports: clk, rst_n (sync active-low); req_* request handshake and fields;
//        memWrite/memRead/addr/dataIn/dataOut memory port;
//        resp_valid/resp_data read return; done completion pulse.
// READ_LAT counts edges from the strobe register edge to the edge that
// samples dataOut, so beat i returns 1+i+READ_LAT cycles after accept.
module mem_access_master
  import mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int LEN_W    = MEM_LEN_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              memWrite,
  output logic              memRead,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              done
);
  state_t            state, state_nxt;
  logic [LEN_W-1:0]  beat, beat_nxt, len_q, len_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              ready_nxt, wr_nxt, rd_nxt, done_nxt;
  logic              exit_valid, pipe_busy;

  // rd_nxt is the strobe registered this edge, so the beat enters the pipe
  // on the same edge that puts it on the memory port.
  rd_valid_pipe #(.DEPTH(READ_LAT)) u_rd_pipe (
    .clk        (clk),
    .clr_n      (rst_n),
    .issue      (rd_nxt),
    .exit_valid (exit_valid),
    .busy       (pipe_busy)
  );

  // Next-state and next-output decode; every output is a flop loaded from here.
  always_comb begin
    state_nxt = state;
    ready_nxt = req_ready;
    beat_nxt  = beat;
    len_nxt   = len_q;
    addr_nxt  = addr;
    din_nxt   = dataIn;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: if (req_valid && req_ready) begin
        ready_nxt = 1'b0;
        addr_nxt  = req_addr;
        beat_nxt  = '0;
        len_nxt   = req_len;
        if (req_write) begin
          state_nxt = WRITE;
          wr_nxt    = 1'b1;
          din_nxt   = req_wdata;
        end else begin
          state_nxt = READ;
          rd_nxt    = 1'b1;
        end
      end
      WRITE: if (beat == len_q) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end else begin
        wr_nxt   = 1'b1;
        addr_nxt = addr + 1'b1;
        din_nxt  = dataIn + 1'b1;
        beat_nxt = beat + 1'b1;
      end
      READ: if (beat == len_q) begin
        state_nxt = DRAIN;
      end else begin
        rd_nxt   = 1'b1;
        addr_nxt = addr + 1'b1;
        beat_nxt = beat + 1'b1;
      end
      // Last response is out once nothing is left in flight.
      DRAIN: if (!pipe_busy && resp_valid) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      beat       <= '0;
      len_q      <= '0;
      memWrite   <= 1'b0;
      memRead    <= 1'b0;
      addr       <= '0;
      dataIn     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_ready  <= ready_nxt;
      beat       <= beat_nxt;
      len_q      <= len_nxt;
      memWrite   <= wr_nxt;
      memRead    <= rd_nxt;
      addr       <= addr_nxt;
      dataIn     <= din_nxt;
      resp_valid <= exit_valid;
      done       <= done_nxt;
      // Only capture dataOut for an exiting beat so idle-bus X never leaks.
      if (exit_valid) resp_data <= dataOut;
    end
  end
endmodule

// File: tb/tb_mem_access_master.sv
module tb_mem_access_master;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready, req_write, mem_wr, mem_rd, resp_valid, done;
  logic [1:0][7:0] req_addr, req_wdata, addr, din, dout, resp_data;
  logic [1:0][2:0] req_len;
  logic [7:0]      mem [2][256];
  logic [7:0]      lat_a, lat_b;

  int cyc = 0, checks = 0, errors = 0, both = 0;
  int bw, br, bs, bd;
  int wr_a[$], wr_d[$], wr_t[$], rd_a[$], rd_t[$], rs_d[$], rs_t[$], dn_t[$];
  int r1_t[$], s1_d[$], s1_t[$], d1_t[$];

  localparam logic [31:0] RST = 32'h1000_0000;

  mem_access_master #(.READ_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_len(req_len[0]), .memWrite(mem_wr[0]), .memRead(mem_rd[0]), .addr(addr[0]),
    .dataIn(din[0]), .dataOut(dout[0]), .resp_valid(resp_valid[0]),
    .resp_data(resp_data[0]), .done(done[0]));

  mem_access_master #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_len(req_len[1]), .memWrite(mem_wr[1]), .memRead(mem_rd[1]), .addr(addr[1]),
    .dataIn(din[1]), .dataOut(dout[1]), .resp_valid(resp_valid[1]),
    .resp_data(resp_data[1]), .done(done[1]));

  // Memory responders: instance 0 reads combinationally (READ_LAT=1),
  // instance 1 adds two output registers (READ_LAT=3).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < 2; s++) if (mem_wr[s]) mem[s][addr[s]] <= din[s];
    lat_a <= mem_rd[1] ? mem[1][addr[1]] : 8'hxx;
    lat_b <= lat_a;
  end
  assign dout[0] = mem_rd[0] ? mem[0][addr[0]] : 8'hxx;
  assign dout[1] = lat_b;

  always @(negedge clk) begin
    if (mem_wr[0]) begin wr_a.push_back(int'(addr[0])); wr_d.push_back(int'(din[0])); wr_t.push_back(cyc); end
    if (mem_rd[0]) begin rd_a.push_back(int'(addr[0])); rd_t.push_back(cyc); end
    if (resp_valid[0]) begin rs_d.push_back(int'(resp_data[0])); rs_t.push_back(cyc); end
    if (done[0]) dn_t.push_back(cyc);
    if (mem_rd[1]) r1_t.push_back(cyc);
    if (resp_valid[1]) begin s1_d.push_back(int'(resp_data[1])); s1_t.push_back(cyc); end
    if (done[1]) d1_t.push_back(cyc);
    if ((mem_wr[0] && mem_rd[0]) || (mem_wr[1] && mem_rd[1])) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int s);
    return {3'b0, req_ready[s], mem_wr[s], mem_rd[s], resp_valid[s], done[s],
            addr[s], din[s], resp_data[s]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    bw = wr_a.size(); br = rd_a.size(); bs = rs_d.size(); bd = dn_t.size();
  endtask

  // Offer a request and hold it until accepted; tacc is the handshake cycle.
  task automatic send(input int s, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [2:0] l, output int tacc);
    tacc = -1;
    @(negedge clk);
    req_valid[s] = 1'b1; req_write[s] = w; req_addr[s] = a; req_wdata[s] = d; req_len[s] = l;
    for (int k = 0; k < 40; k++) begin
      if (req_ready[s]) begin tacc = cyc; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid[s] = 1'b0;
    if (tacc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic exp_write(input string tag, input int t, input logic [7:0] a0,
                           input logic [7:0] d0, input int n);
    chk({tag, "_nwr"}, wr_a.size() - bw, n);
    chk({tag, "_nrd"}, rd_a.size() - br, 0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_a[bw+i], 8'(a0 + i));
      chk($sformatf("%s_data%0d", tag, i), wr_d[bw+i], 8'(d0 + i));
      chk($sformatf("%s_time%0d", tag, i), wr_t[bw+i], t + 1 + i);
    end
    chk({tag, "_ndone"}, dn_t.size() - bd, 1);
    chk({tag, "_done_t"}, dn_t[bd], t + n + 1);
  endtask

  task automatic exp_read(input string tag, input int t, input logic [7:0] a0,
                          input logic [7:0] d0, input int n);
    chk({tag, "_nrd"}, rd_a.size() - br, n);
    chk({tag, "_nresp"}, rs_d.size() - bs, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), rd_a[br+i], 8'(a0 + i));
      chk($sformatf("%s_rtime%0d", tag, i), rd_t[br+i], t + 1 + i);
      chk($sformatf("%s_data%0d", tag, i), rs_d[bs+i], 8'(d0 + i));
      chk($sformatf("%s_time%0d", tag, i), rs_t[bs+i], t + 2 + i);
    end
    chk({tag, "_ndone"}, dn_t.size() - bd, 1);
    chk({tag, "_done_t"}, dn_t[bd], t + n + 2);
  endtask

  initial begin
    int t, t2, b1r, b1s, b1d;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_len = '0;
    idle(3);
    chk("rst_dut0", outs(0), RST);
    chk("rst_dut3", outs(1), RST);
    rst_n = 1'b1;
    idle(2);

    // 1: 8-beat write 0..7
    snap(); send(0, 1'b1, 8'h00, 8'h00, 3'd7, t); idle(14);
    exp_write("t1", t, 8'h00, 8'h00, 8);

    // 2: read it back
    snap(); send(0, 1'b0, 8'h00, 8'h00, 3'd7, t); idle(16);
    exp_read("t2", t, 8'h00, 8'h00, 8);

    // 3: address and data wrap, then read-back
    snap(); send(0, 1'b1, 8'hFE, 8'hFF, 3'd3, t); idle(10);
    exp_write("t3w", t, 8'hFE, 8'hFF, 4);
    snap(); send(0, 1'b0, 8'hFE, 8'h00, 3'd3, t); idle(10);
    exp_read("t3r", t, 8'hFE, 8'hFF, 4);

    // 4: request offered while busy waits until the cycle after done
    snap(); send(0, 1'b0, 8'h00, 8'h00, 3'd7, t);
    chk("t4_busy_ready", req_ready[0], 1'b0);
    send(0, 1'b1, 8'h40, 8'hAA, 3'd0, t2);
    chk("t4_accept_t", t2, t + 11);
    idle(6);
    chk("t4_nwr", wr_a.size() - bw, 1);
    chk("t4_waddr", wr_a[bw], 8'h40);
    chk("t4_wdata", wr_d[bw], 8'hAA);
    chk("t4_nresp", rs_d.size() - bs, 8);
    chk("t4_ndone", dn_t.size() - bd, 2);
    chk("t4_done_t", dn_t[bd], t + 10);

    // 5: reset on the 3rd beat of an 8-beat read
    snap(); send(0, 1'b0, 8'h00, 8'h00, 3'd7, t);
    while (cyc < t + 3) @(negedge clk);
    chk("t5_beat3", {mem_rd[0], addr[0]}, {1'b1, 8'h02});
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_outs", outs(0), RST);
    rst_n = 1'b1;
    idle(15);
    chk("t5_nresp", rs_d.size() - bs, 2);
    chk("t5_ndone", dn_t.size() - bd, 0);
    chk("t5_ready", req_ready[0], 1'b1);

    // 6: single beat at 0x05, READ_LAT=1
    send(0, 1'b1, 8'h05, 8'h5A, 3'd0, t); idle(4);
    snap(); send(0, 1'b0, 8'h05, 8'h00, 3'd0, t); idle(6);
    exp_read("t6", t, 8'h05, 8'h5A, 1);

    // 6b: same with READ_LAT=3
    send(1, 1'b1, 8'h05, 8'h3C, 3'd0, t); idle(4);
    b1r = r1_t.size(); b1s = s1_d.size(); b1d = d1_t.size();
    send(1, 1'b0, 8'h05, 8'h00, 3'd0, t); idle(10);
    chk("t6b_nrd", r1_t.size() - b1r, 1);
    chk("t6b_rtime", r1_t[b1r], t + 1);
    chk("t6b_nresp", s1_d.size() - b1s, 1);
    chk("t6b_data", s1_d[b1s], 8'h3C);
    chk("t6b_time", s1_t[b1s], t + 4);
    chk("t6b_ndone", d1_t.size() - b1d, 1);
    chk("t6b_done_t", d1_t[b1d], t + 5);

    chk("both_strobes", both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
